// File: rtl/clint_rtc_multi.sv
// Core-local interruptor for NUM_HARTS harts with a fractional-rate mtime tick.
// Exposes msip, mtimecmp and mtime on the data bus with a fixed one-cycle response.
module clint_rtc_multi #(
  parameter int          NUM_HARTS = 4,
  parameter int unsigned CLK_FREQ  = 1000000000,
  parameter int unsigned RTC_FREQ  = 100000000,
  parameter int          ACC_WIDTH = 32
) (
  input  logic                 reset,
  input  logic                 clock,
  input  logic                 mem_valid,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_wstrb,
  output logic [31:0]          mem_rdata,
  output logic                 mem_ready,
  output logic [63:0]          mtime_o,
  output logic [NUM_HARTS-1:0] msip_o,
  output logic [NUM_HARTS-1:0] mtip_o
);

  localparam logic [ACC_WIDTH-1:0] CLK_STEP = ACC_WIDTH'(CLK_FREQ);
  localparam logic [ACC_WIDTH-1:0] RTC_STEP = ACC_WIDTH'(RTC_FREQ);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 tick;

  logic [63:0]          mtime;
  logic [63:0]          mtime_inc;
  logic [63:0]          mtime_next;
  logic [63:0]          mtimecmp [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip;
  logic [NUM_HARTS-1:0] mtip_cmp;

  logic [15:0]          off;
  logic                 is_write;
  logic                 hit_msip;
  logic                 hit_cmp;
  logic                 hit_mtime;
  logic                 word_hi;
  logic [5:0]           msip_idx;
  logic [5:0]           cmp_idx;
  logic [31:0]          rd_val;
  logic                 unused_addr_bits;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  // Phase accumulator: tick whenever the accumulated RTC phase crosses one core-clock period.
  always_comb begin
    acc_sum  = acc + RTC_STEP;
    tick     = (acc_sum >= CLK_STEP);
    acc_next = tick ? (acc_sum - CLK_STEP) : acc_sum;
  end

  assign off              = mem_addr[15:0];
  assign unused_addr_bits = ^{mem_addr[31:16], mem_addr[1:0]};
  assign is_write         = mem_valid && (mem_wstrb != 4'b0000);
  assign hit_msip         = (off[15:8] == 8'h00);
  assign msip_idx         = off[7:2];
  assign hit_cmp          = (off[15:9] == 7'b0100_000);
  assign cmp_idx          = off[8:3];
  assign hit_mtime        = (off[15:3] == 13'h17FF);
  assign word_hi          = off[2];

  // Hart indices beyond NUM_HARTS never match, so those offsets read as zero.
  always_comb begin
    rd_val = '0;
    if (hit_mtime) rd_val = word_hi ? mtime[63:32] : mtime[31:0];
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (hit_msip && (msip_idx == 6'(h))) rd_val = {31'b0, msip[h]};
      if (hit_cmp && (cmp_idx == 6'(h)))
        rd_val = word_hi ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
    end
  end

  // A bus write to one mtime word overrides the tick for that word only; the other keeps the carry.
  always_comb begin
    mtime_inc  = mtime + 64'(tick);
    mtime_next = mtime_inc;
    if (is_write && hit_mtime) begin
      if (word_hi) mtime_next[63:32] = merge_bytes(mtime_inc[63:32], mem_wdata, mem_wstrb);
      else         mtime_next[31:0]  = merge_bytes(mtime_inc[31:0], mem_wdata, mem_wstrb);
    end
  end

  always_comb begin
    mtip_cmp = '0;
    for (int h = 0; h < NUM_HARTS; h++) mtip_cmp[h] = (mtime >= mtimecmp[h]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      mtime <= '0;
    end else begin
      acc   <= acc_next;
      mtime <= mtime_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      msip <= '0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
    end else if (is_write) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (hit_msip && (msip_idx == 6'(h)) && mem_wstrb[0]) msip[h] <= mem_wdata[0];
        if (hit_cmp && (cmp_idx == 6'(h))) begin
          if (word_hi)
            mtimecmp[h][63:32] <= merge_bytes(mtimecmp[h][63:32], mem_wdata, mem_wstrb);
          else
            mtimecmp[h][31:0]  <= merge_bytes(mtimecmp[h][31:0], mem_wdata, mem_wstrb);
        end
      end
    end
  end

  // Response carries the value sampled at acceptance, and is forced to zero between responses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= mem_valid;
      mem_rdata <= mem_valid ? rd_val : '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mtip_o <= '0;
      msip_o <= '0;
    end else begin
      mtip_o <= mtip_cmp;
      msip_o <= msip;
    end
  end

  assign mtime_o = mtime;

endmodule

// File: tb/tb_clint_rtc_multi.sv
// Randomised scoreboard bench for clint_rtc_multi against a tick-count reference model.
// A second instance with a 30:7 clock ratio checks fractional tick spacing.
module tb_clint_rtc_multi;

  localparam int NH = 4;
  localparam longint unsigned CLK_A = 1000000000;
  localparam longint unsigned RTC_A = 100000000;
  localparam longint unsigned CLK_B = 30;
  localparam longint unsigned RTC_B = 7;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          mem_valid = 1'b0;
  logic [31:0]   mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic [3:0]    mem_wstrb = '0;
  logic [31:0]   mem_rdata;
  logic          mem_ready;
  logic [63:0]   mtime_o;
  logic [NH-1:0] msip_o;
  logic [NH-1:0] mtip_o;

  logic [31:0]   b_rdata;
  logic          b_ready;
  logic [63:0]   b_mtime;
  logic [NH-1:0] b_msip;
  logic [NH-1:0] b_mtip;

  int checks = 0;
  int failures = 0;

  longint unsigned kcyc = 0;
  logic [63:0]     mtime_m = '0;
  logic [63:0]     cmp_m [NH];
  logic [NH-1:0]   msip_m = '0;
  logic [NH-1:0]   exp_mtip = '0;
  logic [NH-1:0]   exp_msip = '0;

  typedef struct {
    logic [31:0]     data;
    longint unsigned cyc;
  } exp_t;
  exp_t sbq[$];

  clint_rtc_multi #(.NUM_HARTS(NH), .CLK_FREQ(1000000000), .RTC_FREQ(100000000), .ACC_WIDTH(32)) dut (
    .reset(reset), .clock(clock), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mtime_o(mtime_o), .msip_o(msip_o), .mtip_o(mtip_o)
  );

  clint_rtc_multi #(.NUM_HARTS(NH), .CLK_FREQ(30), .RTC_FREQ(7), .ACC_WIDTH(32)) dut_frac (
    .reset(reset), .clock(clock), .mem_valid(1'b0), .mem_addr(32'h0),
    .mem_wdata(32'h0), .mem_wstrb(4'h0), .mem_rdata(b_rdata),
    .mem_ready(b_ready), .mtime_o(b_mtime), .msip_o(b_msip), .mtip_o(b_mtip)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Total ticks after k clocks is floor(k*RTC/CLK), independent of any accumulator encoding.
  function automatic longint unsigned ticks_upto(input longint unsigned k, input longint unsigned rtc,
                                                 input longint unsigned clk);
    return (k * rtc) / clk;
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] old_word, input logic [31:0] wdata,
                                             input logic [3:0] strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    return res;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int unsigned off;
    int unsigned h;
    off = int'(addr[15:0]);
    if (off < 32'h100) begin
      h = off / 4;
      return (h < NH) ? {31'b0, msip_m[h]} : 32'h0;
    end
    if (off >= 32'h4000 && off < 32'h4200) begin
      h = (off - 32'h4000) / 8;
      if (h >= NH) return 32'h0;
      return ((off % 8) >= 4) ? cmp_m[h][63:32] : cmp_m[h][31:0];
    end
    if (off == 32'hBFF8) return mtime_m[31:0];
    if (off == 32'hBFFC) return mtime_m[63:32];
    return 32'h0;
  endfunction

  // Reference model: advances once per clock; pushes each request's expected response.
  initial begin
    logic [63:0]     inc;
    logic [63:0]     nxt;
    longint unsigned tk;
    int unsigned     off;
    int unsigned     h;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        kcyc = 0;
        mtime_m = '0;
        msip_m = '0;
        exp_mtip = '0;
        exp_msip = '0;
        for (int i = 0; i < NH; i++) cmp_m[i] = '1;
        sbq.delete();
      end else begin
        for (int i = 0; i < NH; i++) exp_mtip[i] = (mtime_m >= cmp_m[i]);
        exp_msip = msip_m;
        kcyc++;
        tk  = ticks_upto(kcyc, RTC_A, CLK_A) - ticks_upto(kcyc - 1, RTC_A, CLK_A);
        inc = mtime_m + tk;
        nxt = inc;
        if (mem_valid) begin
          sbq.push_back('{model_read(mem_addr), kcyc});
          if (mem_wstrb != 4'b0000) begin
            off = int'(mem_addr[15:0]);
            if (off == 32'hBFF8) nxt[31:0] = merge_word(inc[31:0], mem_wdata, mem_wstrb);
            else if (off == 32'hBFFC) nxt[63:32] = merge_word(inc[63:32], mem_wdata, mem_wstrb);
            else if (off < 32'h100) begin
              h = off / 4;
              if (h < NH && mem_wstrb[0]) msip_m[h] = mem_wdata[0];
            end else if (off >= 32'h4000 && off < 32'h4200) begin
              h = (off - 32'h4000) / 8;
              if (h < NH) begin
                if ((off % 8) >= 4) cmp_m[h][63:32] = merge_word(cmp_m[h][63:32], mem_wdata, mem_wstrb);
                else                cmp_m[h][31:0]  = merge_word(cmp_m[h][31:0], mem_wdata, mem_wstrb);
              end
            end
          end
        end
        mtime_m = nxt;
      end
    end
  end

  // Monitor: pops the scoreboard on each response and compares free-running outputs every cycle.
  initial begin
    exp_t            e;
    logic            exp_ready;
    logic [63:0]     last_b = '0;
    longint unsigned last_tick = 0;
    longint unsigned sp;
    forever begin
      @(negedge clock);
      exp_ready = (sbq.size() > 0) && (sbq[0].cyc == kcyc);
      check_output("mem_ready", {63'b0, mem_ready}, {63'b0, exp_ready});
      if (exp_ready) begin
        e = sbq.pop_front();
        check_output("mem_rdata", {32'b0, mem_rdata}, {32'b0, e.data});
      end else begin
        check_output("rdata_idle", {32'b0, mem_rdata}, 64'h0);
      end
      check_output("mtime_o", mtime_o, mtime_m);
      check_output("mtip_o", {60'b0, mtip_o}, {60'b0, exp_mtip});
      check_output("msip_o", {60'b0, msip_o}, {60'b0, exp_msip});
      check_output("frac_mtime", b_mtime, ticks_upto(kcyc, RTC_B, CLK_B));
      if (kcyc == 300) check_output("frac_mtime_300", b_mtime, 64'd70);
      if (!reset) begin
        last_b = '0;
        last_tick = 0;
      end else if (b_mtime != last_b) begin
        if (last_tick != 0) begin
          sp = kcyc - last_tick;
          check_output("frac_spacing_4_or_5", {63'b0, (sp == 4 || sp == 5)}, 64'd1);
        end
        last_tick = kcyc;
        last_b = b_mtime;
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    @(negedge clock);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    logic [31:0] addr_tab [16];
    logic [31:0] a;
    logic [31:0] d;
    int          guard;
    addr_tab = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h4000, 32'h4004, 32'h4008, 32'h400C,
                 32'h4018, 32'h401C, 32'h4020, 32'hBFF8, 32'hBFFC, 32'h8000, 32'h1234};

    repeat (3) @(negedge clock);
    check_output("reset_mtime", mtime_o, 64'h0);
    check_output("reset_ready", {63'b0, mem_ready}, 64'h0);
    reset = 1'b1;

    idle(100);
    check_output("idle_mtime_10", mtime_o, 64'd10);
    check_output("idle_mtip", {60'b0, mtip_o}, 64'h0);

    apply_stimulus(32'h4000, 32'h14, 4'hF);
    apply_stimulus(32'h4004, 32'h0, 4'hF);
    idle(110);
    check_output("mtip_hart0_set", {60'b0, mtip_o}, 64'h1);
    apply_stimulus(32'h4004, 32'h1, 4'hF);
    idle(2);
    check_output("mtip_hart0_clear", {60'b0, mtip_o}, 64'h0);

    apply_stimulus(32'h8, 32'h1, 4'h1);
    idle(1);
    check_output("msip_hart2_set", {60'b0, msip_o}, 64'h4);
    apply_stimulus(32'h8, 32'h0, 4'h0);
    apply_stimulus(32'h8, 32'h0, 4'h1);
    idle(1);
    check_output("msip_hart2_clear", {60'b0, msip_o}, 64'h0);

    apply_stimulus(32'hBFFC, 32'h0, 4'hF);
    apply_stimulus(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    idle(12);
    check_output("mtime_carry_hi", {32'b0, mtime_o[63:32]}, 64'h1);

    guard = 0;
    while (((kcyc + 1) % 10) != 0 && guard < 20) begin
      idle(1);
      guard++;
    end
    check_output("tick_wait_bound", {63'b0, (guard < 20)}, 64'd1);
    apply_stimulus(32'hBFF8, 32'h5, 4'hF);
    check_output("tick_write_collision", mtime_o, 64'h1_0000_0005);

    apply_stimulus(32'h4020, 32'h0, 4'h0);
    idle(1);
    apply_stimulus(32'h8000, 32'h0, 4'h0);
    apply_stimulus(32'h4020, 32'hDEAD_BEEF, 4'hF);
    apply_stimulus(32'h4020, 32'h0, 4'h0);
    idle(1);
    apply_stimulus(32'hBFF8, 32'h0, 4'h0);
    apply_stimulus(32'h4000, 32'h0, 4'h0);
    apply_stimulus(32'h0008, 32'h0, 4'h0);
    idle(2);

    for (int i = 0; i < 300; i++) begin
      a = addr_tab[$urandom_range(0, 15)];
      d = $urandom;
      if (a == 32'hBFFC || (a >= 32'h4000 && a < 32'h4200 && a[2])) d = $urandom_range(0, 3);
      apply_stimulus(a, d, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
      idle($urandom_range(0, 2));
    end
    idle(3);

    mem_valid = 1'b1;
    mem_addr  = 32'hBFF8;
    mem_wstrb = 4'h0;
    #2 reset = 1'b0;
    @(negedge clock);
    mem_valid = 1'b0;
    check_output("rst_mid_ready", {63'b0, mem_ready}, 64'h0);
    check_output("rst_mid_rdata", {32'b0, mem_rdata}, 64'h0);
    check_output("rst_mid_mtime", mtime_o, 64'h0);
    check_output("rst_mid_irq", {56'b0, mtip_o, msip_o}, 64'h0);
    idle(2);
    reset = 1'b1;
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/clint_rtc_multi.md
Name: clint_rtc_multi

Overview:
- Parametrised core-local interruptor for N harts.
- Generates the real-time tick internally from arbitrary CLK_FREQ/RTC_FREQ ratios using a fractional phase accumulator; the ratio need not be an integer.
- Provides 64-bit mtime, per-hart mtimecmp and msip, and registered mtip/msip interrupt outputs.
- Sits on the data memory bus at the CLINT window, next to the print and CLIC slaves.

Parameters:
- NUM_HARTS, 4, number of harts (1..64).
- CLK_FREQ, 1000000000, core clock frequency in Hz.
- RTC_FREQ, 100000000, mtime increment rate in Hz; must be <= CLK_FREQ and > 0.
- ACC_WIDTH, 32, phase accumulator width; must hold CLK_FREQ+RTC_FREQ.

Ports:
- reset  in  1  asynchronous active-low reset
- clock  in  1  core clock
- mem_valid  in  1  request strobe, one cycle per request
- mem_addr  in  32  byte address, offset from CLINT base (bits above 16 ignored)
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte enables; 0000 means read
- mem_rdata  out  32  read data, valid when mem_ready=1
- mem_ready  out  1  response strobe
- mtime_o  out  64  current mtime
- msip_o  out  NUM_HARTS  software interrupt pending, one bit per hart
- mtip_o  out  NUM_HARTS  timer interrupt pending, one bit per hart

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - acc=0, mtime=0, every msip=0, every mtimecmp=64'hFFFF_FFFF_FFFF_FFFF.
  - mem_ready=0, mem_rdata=0, mtip_o=0, msip_o=0.
- Reset asserted mid-transaction drops the pending response; no mem_ready is produced.
- Tick generation, every clock:
  - nxt = acc + RTC_FREQ.
  - If nxt >= CLK_FREQ: acc <= nxt - CLK_FREQ, and tick=1 for that cycle.
  - Otherwise acc <= nxt, tick=0.
  - Long-run tick rate is exactly RTC_FREQ/CLK_FREQ. When RTC_FREQ==CLK_FREQ, tick is high every cycle.
- mtime increments by 1 on tick and wraps from 2^64-1 to 0 with no flag.
- Address map (offsets):
  - 0x0000+4*h: msip[h]. Bit 0 is writable; bits 31:1 read 0.
  - 0x4000+8*h: mtimecmp[h] low word.
  - 0x4004+8*h: mtimecmp[h] high word.
  - 0xBFF8: mtime low word. 0xBFFC: mtime high word.
  - Any other offset, or hart index >= NUM_HARTS, reads 0 and ignores writes; mem_ready is still returned.
- Bus handshake:
  - A request is accepted in the cycle mem_valid=1.
  - mem_ready=1 exactly one cycle later, for one cycle.
  - mem_rdata holds the register value sampled at acceptance and is 0 whenever mem_ready=0.
  - Back-to-back requests on consecutive cycles are supported; each gets its own ready one cycle later.
- Writes:
  - Byte-granular per mem_wstrb and take effect at the clock edge that accepts the request.
  - mtime and mtimecmp are written per 32-bit word; the other word is untouched. No atomic 64-bit update; software uses the high-low-high sequence.
- Collision: a write to an mtime word in a tick cycle wins for that word. The other word still takes the incremented value, including carry into the high word when a low-word write is absent.
- Interrupt outputs, registered one cycle after their source:
  - mtip_o[h] <= (mtime >= mtimecmp[h]), an unsigned 64-bit compare using the post-update mtime.
  - msip_o[h] <= msip[h].
- Latency:
  - Write of mtimecmp[h] below the current mtime -> mtip_o[h] high 2 cycles after acceptance.
  - Write of msip -> msip_o high 2 cycles after acceptance.

Test Plan:
- Defaults, no bus traffic for 100 clocks after reset release -> tick every 10th cycle, mtime_o=10; mtip_o=0 and msip_o=0 throughout.
- CLK_FREQ=30, RTC_FREQ=7, run 300 clocks -> mtime_o=70. Tick spacing alternates 4/5 cycles, never 3 or 6; no cumulative drift.
- Defaults; write 0x4000=0x00000014, then 0x4004=0 -> mtip_o[0] rises on the second cycle after mtime reaches 20. Hart 1..3 mtip stay 0. Rewriting 0x4004=1 clears mtip_o[0] 2 cycles later.
- Write 0x0008 wdata=1 wstrb=0001 -> msip_o=4'b0100 two cycles later. Read 0x0008 -> mem_rdata=1 with ready one cycle after valid. Write wdata=0 -> cleared.
- Preload mtime=0x0000_0000_FFFF_FFFF via two writes, then wait for tick -> mtime_o=0x0000_0001_0000_0000. Write 0xBFF8=5 in a tick cycle -> low word=5, high word unchanged.
- Read 0x4020 with NUM_HARTS=4, and read 0x8000 -> mem_rdata=0, mem_ready pulses once. Issue 3 back-to-back reads -> 3 consecutive ready pulses. Assert reset mid-request -> no ready, all outputs at reset values.
